// File: rtl/inc_pkg.sv
// -----------------------------------------------------------------------------
// inc_pkg
// Shared definitions for the bit-serial incrementer:
//   - inc_state_t        : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - INC_WIDTH_DEFAULT  : default operand/result width
//   - INC_IDX_W          : bit counter width for the default width
//   - inc_idx_width()    : bit counter width for an arbitrary width
// No ports (package).
// -----------------------------------------------------------------------------
package inc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } inc_state_t;

  localparam int INC_WIDTH_DEFAULT = 4;
  localparam int INC_IDX_W         = $clog2(INC_WIDTH_DEFAULT);

  // The bit counter must index positions 0..width-1. The lower clamp keeps the
  // counter at least one bit wide even for degenerate widths.
  function automatic int inc_idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fulladder1.sv
// -----------------------------------------------------------------------------
// fulladder1
// Purpose: 1-bit full adder slice, reused one bit per clock by the serial
//          incrementer.
// Ports:
//   a, b  in  1  addend bits
//   cin   in  1  carry in
//   sum   out 1  a ^ b ^ cin
//   cout  out 1  carry out
// -----------------------------------------------------------------------------
module fulladder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/increment_serial.sv
// -----------------------------------------------------------------------------
// increment_serial
// Purpose: bit-serial WIDTH-bit incrementer, S = A + 1, with valid/ready
//          handshakes on input and output. One bit is processed per clock
//          through a single fulladder1 slice whose carry-in supplies the +1.
//
// Parameters:
//   WIDTH      operand/result width, legal range 2..16
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand A is valid
//   in_ready   out  1      block can accept an operand (state == IDLE)
//   A          in   WIDTH  operand, sampled only at acceptance
//   out_valid  out  1      result is valid (registered)
//   out_ready  in   1      consumer accepts the result
//   S          out  WIDTH  A + 1 (wrapped or saturated), registered
//   ca_out     out  1      carry out of the MSB, registered
//
// Build option:
//   INC_SATURATE_EN  when defined, an overflowing result is forced to
//                    all-ones (ca_out still flags the overflow). When
//                    undefined the result wraps modulo 2^WIDTH.
//   FSM, latency and handshake are identical in both builds.
// -----------------------------------------------------------------------------
module increment_serial
  import inc_pkg::*;
#(
  parameter int WIDTH = INC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             ca_out
);

  localparam int              IDX_W    = inc_idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  inc_state_t       r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_carry;
  logic [IDX_W-1:0] r_bit_idx;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_ca;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_s_final;
  logic             w_last;

  // B is constant zero: the initial carry of 1 is the increment.
  fulladder1 u_fa (
    .a    (r_shift[0]),
    .b    (1'b0),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // LSB leaves at the bottom, sum bit enters at the top; after WIDTH shifts
  // the register holds the full result in natural bit order.
  assign w_shift_next = {w_sum, r_shift[WIDTH-1:1]};
  assign w_last       = (r_bit_idx == LAST_IDX);

`ifdef INC_SATURATE_EN
  assign w_s_final = w_cout ? {WIDTH{1'b1}} : w_shift_next;
`else
  assign w_s_final = w_shift_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_carry     <= 1'b0;
      r_bit_idx   <= '0;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_ca        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift   <= A;
            r_carry   <= 1'b1;
            r_bit_idx <= '0;
            r_state   <= RUN;
          end
        end

        RUN: begin
          r_shift   <= w_shift_next;
          r_carry   <= w_cout;
          r_bit_idx <= r_bit_idx + 1'b1;
          // The output registers are loaded from the final slice outputs so
          // they are valid on the same edge the FSM enters DONE.
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_s         <= w_s_final;
            r_ca        <= w_cout;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign ca_out    = r_ca;

endmodule

// File: tb/tb_increment_serial.sv
// -----------------------------------------------------------------------------
// tb_increment_serial
// Self-checking bench for increment_serial at WIDTH=4 and WIDTH=8. Expected
// results come from an arithmetic model of A+1 (wrap or saturate depending on
// INC_SATURATE_EN).
// -----------------------------------------------------------------------------
module tb_increment_serial;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, ca4;
  logic [3:0] A4, S4;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, ca8;
  logic [7:0] A8, S8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  increment_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .A(A4),
    .out_valid(out_valid4), .out_ready(out_ready4), .S(S4), .ca_out(ca4)
  );

  increment_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .A(A8),
    .out_valid(out_valid8), .out_ready(out_ready8), .S(S8), .ca_out(ca8)
  );

  // Reference: plain integer arithmetic on the operand value.
  function automatic void ref_inc(input int w, input int a, output int s, output bit c);
    int full;
    int sum;
    full = 1 << w;
    sum  = a + 1;
    c    = (sum == full);
`ifdef INC_SATURATE_EN
    s = c ? (full - 1) : sum;
`else
    s = sum % full;
`endif
  endfunction

  // One complete transaction on the selected DUT. Entered and left at a
  // negedge. Returns the result, the latency (negedges from the accept sample
  // to the first out_valid sample), whether S/ca_out held while stalled, and
  // a timeout flag.
  task automatic do_txn(input int w, input logic [7:0] a, input bit rnd,
                        output logic [7:0] s, output logic ca, output int lat,
                        output bit stable, output bit to);
    int guard;
    bit use_rnd;
    to = 0; stable = 1; lat = 0; s = '0; ca = 0; use_rnd = rnd;
    if (w == 4) begin in_valid4 = 1; A4 = a[3:0]; out_ready4 = 0; end
    else        begin in_valid8 = 1; A8 = a;      out_ready8 = 0; end
    guard = 0;
    while (!((w == 4) ? in_ready4 : in_ready8)) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin to = 1; return; end
    end
    @(negedge clk);
    if (w == 4) begin in_valid4 = 0; A4 = 4'($urandom); end
    else        begin in_valid8 = 0; A8 = 8'($urandom); end
    lat = 1;
    while (!((w == 4) ? out_valid4 : out_valid8)) begin
      @(negedge clk);
      lat++;
      if (lat > 60) begin to = 1; return; end
    end
    s  = (w == 4) ? {4'b0, S4} : S8;
    ca = (w == 4) ? ca4 : ca8;
    guard = 0;
    forever begin
      bit r;
      r = use_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w == 4) out_ready4 = r; else out_ready8 = r;
      @(negedge clk);
      if (r) break;
      if (w == 4) begin
        if (!out_valid4 || S4 !== s[3:0] || ca4 !== ca) stable = 0;
      end else begin
        if (!out_valid8 || S8 !== s || ca8 !== ca) stable = 0;
      end
      guard++;
      if (guard > 20) use_rnd = 0;
    end
    if (w == 4) out_ready4 = 0; else out_ready8 = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    total++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || S4 !== 4'h0 || ca4 !== 1'b0) begin
      bad++;
      $display("FAIL reset4: got in_ready=%b out_valid=%b S=%h ca=%b, want 1 0 0 0",
               in_ready4, out_valid4, S4, ca4);
    end
    total++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || S8 !== 8'h00 || ca8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8: got in_ready=%b out_valid=%b S=%h ca=%b, want 1 0 00 0",
               in_ready8, out_valid8, S8, ca8);
    end
    $display("reset: in_ready4=%b out_valid4=%b S4=%h ca4=%b", in_ready4, out_valid4, S4, ca4);
  endtask

  task automatic test_basic();
    bit early;
    early = 0;
    A4 = 4'b0101; in_valid4 = 1; out_ready4 = 1;
    total++;
    if (in_ready4 !== 1'b1) begin
      bad++; $display("FAIL basic_accept: in_ready=%b want 1", in_ready4);
    end
    @(negedge clk);
    in_valid4 = 0; A4 = 4'b1010;
    for (int c = 1; c < 5; c++) begin
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b0) early = 1;
      @(negedge clk);
    end
    total++;
    if (early) begin
      bad++; $display("FAIL basic_run: out_valid or in_ready high during RUN, want both 0");
    end
    total++;
    if (out_valid4 !== 1'b1 || S4 !== 4'b0110 || ca4 !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: out_valid=%b S=%b ca=%b, want 1 0110 0", out_valid4, S4, ca4);
    end
    $display("basic: A=0101 S=%b ca=%b", S4, ca4);
    @(negedge clk);
    out_ready4 = 0;
    total++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      bad++;
      $display("FAIL basic_return: in_ready=%b out_valid=%b, want 1 0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] s; logic ca; int lat; bit st, to;
    int es; bit ec;
    ref_inc(4, 15, es, ec);
    do_txn(4, 8'h0F, 0, s, ca, lat, st, to);
    total++;
    if (to || s[3:0] !== 4'(es) || ca !== ec) begin
      bad++;
      $display("FAIL overflow: S=%b ca=%b timeout=%0d, want S=%b ca=%b", s[3:0], ca, to, 4'(es), ec);
    end
    $display("overflow: A=1111 S=%b ca=%b", s[3:0], ca);
  endtask

  task automatic test_backpressure();
    int guard;
    bit hold_ok;
    int transfers;
    hold_ok = 1; transfers = 0; guard = 0;
    A4 = 4'b0111; in_valid4 = 1; out_ready4 = 0;
    @(negedge clk);
    in_valid4 = 0;
    while (!out_valid4 && guard < 30) begin @(negedge clk); guard++; end
    total++;
    if (!out_valid4) begin
      bad++; $display("FAIL bp_wait: out_valid=%b want 1 within 30 cycles", out_valid4);
    end
    for (int c = 0; c < 10; c++) begin
      if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || S4 !== 4'b1000 || ca4 !== 1'b0)
        hold_ok = 0;
      in_valid4 = 1'($urandom_range(0, 1));
      A4 = 4'($urandom);
      @(negedge clk);
    end
    total++;
    if (!hold_ok) begin
      bad++;
      $display("FAIL bp_hold: S=%b out_valid=%b in_ready=%b, want 1000 1 0 held", S4, out_valid4, in_ready4);
    end
    in_valid4 = 0; out_ready4 = 1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid4 && out_ready4) transfers++;
      @(negedge clk);
    end
    out_ready4 = 0;
    total++;
    if (transfers != 1) begin
      bad++; $display("FAIL bp_transfers: got %0d want 1", transfers);
    end
    $display("backpressure: A=0111 S=1000 transfers=%0d", transfers);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    logic [7:0] s; logic ca; int lat; bit st, to;
    seen = 0;
    A4 = 4'b0011; in_valid4 = 1; out_ready4 = 1;
    @(negedge clk);
    in_valid4 = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    total++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      bad++;
      $display("FAIL midrun_abort: in_ready=%b out_valid=%b, want 1 0", in_ready4, out_valid4);
    end
    for (int c = 0; c < 8; c++) begin
      if (out_valid4) seen = 1;
      @(negedge clk);
    end
    out_ready4 = 0;
    total++;
    if (seen) begin
      bad++; $display("FAIL midrun_novalid: out_valid seen=1 want 0");
    end
    do_txn(4, 8'h00, 0, s, ca, lat, st, to);
    total++;
    if (to || s[3:0] !== 4'b0001 || ca !== 1'b0) begin
      bad++; $display("FAIL midrun_fresh: S=%b ca=%b want 0001 0", s[3:0], ca);
    end
    $display("reset_mid_run: fresh A=0000 S=%b ca=%b", s[3:0], ca);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int expq[$];
    int es; bit ec;
    bit accepted;
    A4 = 4'($urandom); in_valid4 = 1; out_ready4 = 1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      in_valid4 = (cyc < 19);
      accepted = 0;
      if (out_valid4) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL b2b_extra: unexpected out_valid at cycle %0d", cyc);
        end else begin
          es = expq.pop_front();
          if (S4 !== 4'(es)) begin
            bad++; $display("FAIL b2b_result: S=%b want %b", S4, 4'(es));
          end
        end
      end
      if (in_valid4 && in_ready4) begin
        acc.push_back(cyc);
        ref_inc(4, int'(A4), es, ec);
        expq.push_back(es);
        accepted = 1;
      end
      @(posedge clk);
      #1;
      if (accepted) A4 = 4'($urandom);
      @(negedge clk);
    end
    in_valid4 = 0; out_ready4 = 0;
    total++;
    if (acc.size() != 4 || expq.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: accepts=%0d pending=%0d want 4 0", acc.size(), expq.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] != 6) begin
        bad++; $display("FAIL b2b_period: interval=%0d want 6", acc[i] - acc[i-1]);
      end
    end
    $display("back_to_back: accepts=%0d", acc.size());
  endtask

  task automatic test_sweep4();
    logic [7:0] s; logic ca; int lat; bit st, to;
    int es; bit ec;
    for (int a = 0; a < 16; a++) begin
      ref_inc(4, a, es, ec);
      do_txn(4, 8'(a), 1, s, ca, lat, st, to);
      total++;
      if (to || s[3:0] !== 4'(es) || ca !== ec || lat != 5 || !st) begin
        bad++;
        $display("FAIL sweep4: A=%h S=%h ca=%b lat=%0d stable=%0d to=%0d, want S=%h ca=%b lat=5",
                 4'(a), s[3:0], ca, lat, st, to, 4'(es), ec);
      end
      $display("sweep4: A=%h S=%h ca=%b lat=%0d", 4'(a), s[3:0], ca, lat);
    end
  endtask

  task automatic test_random8();
    logic [7:0] s; logic ca; int lat; bit st, to;
    logic [7:0] a;
    int es; bit ec;
    for (int n = 0; n < 100; n++) begin
      a = (n == 0) ? 8'hFF : 8'($urandom);
      ref_inc(8, int'(a), es, ec);
      do_txn(8, a, 1, s, ca, lat, st, to);
      total++;
      if (to || s !== 8'(es) || ca !== ec || lat != 9 || !st) begin
        bad++;
        $display("FAIL random8: A=%h S=%h ca=%b lat=%0d stable=%0d to=%0d, want S=%h ca=%b lat=9",
                 a, s, ca, lat, st, to, 8'(es), ec);
      end
      $display("random8: A=%h S=%h ca=%b lat=%0d", a, s, ca, lat);
    end
  endtask

  initial begin
    rst_n = 0;
    in_valid4 = 0; A4 = '0; out_ready4 = 0;
    in_valid8 = 0; A8 = '0; out_ready8 = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep4();
    test_random8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
